// File: rtl/game_ctrl.sv
// Breakout game sequencer: serve/play/lose/win flow, lives and score keeping.
// Optional pause support is compiled in with `define GAME_PAUSE_EN.
module game_ctrl #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int LOST_Y       = 470,
  parameter int WIN_SCORE    = 32
) (
  input  logic       pxl_clk,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic [9:0] ball_y,
  input  logic       brick_hit,
  output logic       ball_start,
  output logic       ball_rst_n,
  output logic       ball_vsync,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic [2:0] game_state,
  output logic       game_over
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    LOST  = 3'd3,
    OVER  = 3'd4,
    WIN   = 3'd5,
    PAUSE = 3'd6,
    BAD   = 3'd7
  } state_t;

  localparam logic [1:0] LIVES_V  = 2'(LIVES);
  localparam logic [7:0] SERVE_V  = 8'(SERVE_FRAMES);
  localparam logic [9:0] LOST_V   = 10'(LOST_Y);
  localparam logic [7:0] WIN_V    = 8'(WIN_SCORE);

  state_t     state_r;
  logic [7:0] frame_cnt_r;
  logic       vsync_q_r;
  logic       start_q_r;
  logic       vsync_tick_s;
  logic       start_tick_s;
  logic [7:0] score_inc_s;
  logic [7:0] score_nxt_s;
  logic       loss_s;
  logic       win_pending_s;

  assign vsync_tick_s  = vsync & ~vsync_q_r;
  assign start_tick_s  = btn_start & ~start_q_r;
  assign score_inc_s   = (score == 8'hFF) ? score : score + 8'd1;
  assign score_nxt_s   = brick_hit ? score_inc_s : score;
  assign loss_s        = vsync_tick_s && (ball_y >= LOST_V);
  // A hit that completes the win masks a loss seen in the same cycle.
  assign win_pending_s = brick_hit && (score_inc_s == WIN_V);

  assign game_state = state_r;
  assign game_over  = (state_r == OVER) || (state_r == WIN);

`ifdef GAME_PAUSE_EN
  logic pause_q_r;
  logic pause_tick_s;
  assign pause_tick_s = btn_pause & ~pause_q_r;
  assign ball_vsync   = vsync && (state_r != PAUSE);

  // Pause button edge-detect register.
  always_ff @(posedge pxl_clk or negedge reset_n) begin
    if (!reset_n) pause_q_r <= 1'b0;
    else          pause_q_r <= btn_pause;
  end
`else
  logic unused_pause_s;
  assign unused_pause_s = btn_pause;
  assign ball_vsync     = vsync;
`endif

  // Edge-detect registers for vsync and start.
  always_ff @(posedge pxl_clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q_r <= 1'b0;
      start_q_r <= 1'b0;
    end else begin
      vsync_q_r <= vsync;
      start_q_r <= btn_start;
    end
  end

  // Game FSM with registered lives, score, frame counter and ball controls.
  always_ff @(posedge pxl_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      lives       <= LIVES_V;
      score       <= 8'd0;
      frame_cnt_r <= 8'd0;
      ball_start  <= 1'b0;
      ball_rst_n  <= 1'b0;
    end else begin
      ball_start <= 1'b0;
      case (state_r)
        IDLE: begin
          lives      <= LIVES_V;
          score      <= 8'd0;
          ball_rst_n <= 1'b0;
          if (start_tick_s) begin
            state_r     <= SERVE;
            frame_cnt_r <= 8'd0;
            ball_rst_n  <= 1'b1;
          end
        end
        SERVE: begin
          ball_rst_n <= 1'b1;
          if (vsync_tick_s) begin
            frame_cnt_r <= frame_cnt_r + 8'd1;
            if ((frame_cnt_r + 8'd1) == SERVE_V) begin
              ball_start <= 1'b1;
              state_r    <= PLAY;
            end
          end
        end
        PLAY: begin
          ball_rst_n <= 1'b1;
          if (score == WIN_V) begin
            state_r    <= WIN;
            ball_rst_n <= 1'b0;
          end else begin
            score <= score_nxt_s;
`ifdef GAME_PAUSE_EN
            if (pause_tick_s) begin
              state_r <= PAUSE;
            end else if (loss_s && !win_pending_s) begin
              state_r    <= LOST;
              ball_rst_n <= 1'b0;
            end
`else
            if (loss_s && !win_pending_s) begin
              state_r    <= LOST;
              ball_rst_n <= 1'b0;
            end
`endif
          end
        end
        LOST: begin
          if (lives <= 2'd1) begin
            lives      <= 2'd0;
            state_r    <= OVER;
            ball_rst_n <= 1'b0;
          end else begin
            lives       <= lives - 2'd1;
            state_r     <= SERVE;
            frame_cnt_r <= 8'd0;
            ball_rst_n  <= 1'b1;
          end
        end
        OVER, WIN: begin
          ball_rst_n <= 1'b0;
          if (start_tick_s) begin
            state_r <= IDLE;
            lives   <= LIVES_V;
            score   <= 8'd0;
          end
        end
`ifdef GAME_PAUSE_EN
        PAUSE: begin
          ball_rst_n <= 1'b1;
          if (pause_tick_s) state_r <= PLAY;
        end
`endif
        default: begin
          state_r     <= IDLE;
          lives       <= LIVES_V;
          score       <= 8'd0;
          frame_cnt_r <= 8'd0;
          ball_rst_n  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: stimulus pushes expectations, a negedge
// monitor pops them on every ball_start pulse or explicit sample request.
module tb_game_ctrl;

  logic       pxl_clk = 1'b0;
  logic       reset_n;
  logic       vsync;
  logic       btn_start;
  logic       btn_pause;
  logic [9:0] ball_y;
  logic       brick_hit;
  logic       ball_start;
  logic       ball_rst_n;
  logic       ball_vsync;
  logic [1:0] lives;
  logic [7:0] score;
  logic [2:0] game_state;
  logic       game_over;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic [1:0] lv;
    logic [7:0] sc;
    logic       rstn;
    logic       start;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic sample_req = 1'b0;
  logic exp_paused = 1'b0;

  game_ctrl dut (
    .pxl_clk    (pxl_clk),
    .reset_n    (reset_n),
    .vsync      (vsync),
    .btn_start  (btn_start),
    .btn_pause  (btn_pause),
    .ball_y     (ball_y),
    .brick_hit  (brick_hit),
    .ball_start (ball_start),
    .ball_rst_n (ball_rst_n),
    .ball_vsync (ball_vsync),
    .lives      (lives),
    .score      (score),
    .game_state (game_state),
    .game_over  (game_over)
  );

  always #5 pxl_clk = ~pxl_clk;

  // Monitor: pops an expectation whenever the DUT launches or a sample is requested.
  always @(negedge pxl_clk) begin
    checks++;
    if (ball_vsync !== (vsync & ~exp_paused)) begin
      failures++;
      $display("FAIL ball_vsync got=%b exp=%b t=%0t", ball_vsync, vsync & ~exp_paused, $time);
    end
    if (sample_req || ball_start) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output ball_start=%b exp_queue=empty t=%0t", ball_start, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks += 6;
        if (game_state !== e.st) begin
          failures++;
          $display("FAIL %s.state got=%0d exp=%0d", e.name, game_state, e.st);
        end
        if (lives !== e.lv) begin
          failures++;
          $display("FAIL %s.lives got=%0d exp=%0d", e.name, lives, e.lv);
        end
        if (score !== e.sc) begin
          failures++;
          $display("FAIL %s.score got=%0d exp=%0d", e.name, score, e.sc);
        end
        if (ball_rst_n !== e.rstn) begin
          failures++;
          $display("FAIL %s.ball_rst_n got=%b exp=%b", e.name, ball_rst_n, e.rstn);
        end
        if (ball_start !== e.start) begin
          failures++;
          $display("FAIL %s.ball_start got=%b exp=%b", e.name, ball_start, e.start);
        end
        if (game_over !== ((e.st == 3'd4) || (e.st == 3'd5))) begin
          failures++;
          $display("FAIL %s.game_over got=%b exp=%b", e.name, game_over,
                   (e.st == 3'd4) || (e.st == 3'd5));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge pxl_clk);
    #1;
  endtask

  task automatic push(input string n, input logic [2:0] st, input logic [1:0] lv,
                      input logic [7:0] sc, input logic rstn, input logic start);
    exp_t e;
    e.name = n; e.st = st; e.lv = lv; e.sc = sc; e.rstn = rstn; e.start = start;
    exp_q.push_back(e);
  endtask

  task automatic check(input string n, input logic [2:0] st, input logic [1:0] lv,
                       input logic [7:0] sc, input logic rstn);
    push(n, st, lv, sc, rstn, 1'b0);
    sample_req = 1'b1;
    @(negedge pxl_clk);
    #1;
    sample_req = 1'b0;
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1; cyc();
    vsync = 1'b0; cyc();
  endtask

  task automatic hit();
    brick_hit = 1'b1; cyc();
    brick_hit = 1'b0; cyc();
  endtask

  task automatic press_start();
    btn_start = 1'b1; cyc();
    btn_start = 1'b0; cyc();
  endtask

  task automatic serve_to_play(input logic [1:0] lv, input logic [7:0] sc);
    for (int i = 0; i < 59; i++) vsync_pulse();
    check("serve59", 3'd1, lv, sc, 1'b1);
    push("launch", 3'd2, lv, sc, 1'b1, 1'b1);
    vsync_pulse();
    check("play", 3'd2, lv, sc, 1'b1);
  endtask

  // Loss sequence: vsync edge with ball at the bottom, optional coincident hit.
  task automatic lose(input string n, input logic [1:0] lv, input logic [7:0] sc_lost,
                      input logic with_hit, input logic [2:0] st_after,
                      input logic [1:0] lv_after, input logic rstn_after);
    ball_y = 10'd470; vsync = 1'b1; brick_hit = with_hit;
    cyc();
    brick_hit = 1'b0;
    check(n, 3'd3, lv, sc_lost, 1'b0);
    vsync = 1'b0; ball_y = 10'd0;
    cyc();
    check({n, "_after"}, st_after, lv_after, sc_lost, rstn_after);
  endtask

  initial begin
    reset_n = 1'b0; vsync = 1'b0; btn_start = 1'b0; btn_pause = 1'b0;
    ball_y = 10'd0; brick_hit = 1'b0;
    cyc(); cyc(); cyc();
    check("reset", 3'd0, 2'd3, 8'd0, 1'b0);
    reset_n = 1'b1;
    cyc();
    check("idle_hold", 3'd0, 2'd3, 8'd0, 1'b0);

    // First serve and launch on the 60th frame.
    press_start();
    check("serve", 3'd1, 2'd3, 8'd0, 1'b1);
    serve_to_play(2'd3, 8'd0);
    for (int i = 0; i < 5; i++) hit();
    check("hits5", 3'd2, 2'd3, 8'd5, 1'b1);

`ifdef GAME_PAUSE_EN
    btn_pause = 1'b1; cyc(); exp_paused = 1'b1; btn_pause = 1'b0;
    check("pause", 3'd6, 2'd3, 8'd5, 1'b1);
    ball_y = 10'd470;
    vsync_pulse(); hit(); vsync_pulse(); press_start();
    check("paused_hold", 3'd6, 2'd3, 8'd5, 1'b1);
    ball_y = 10'd0;
    btn_pause = 1'b1; cyc(); exp_paused = 1'b0; btn_pause = 1'b0;
    check("resume", 3'd2, 2'd3, 8'd5, 1'b1);
`else
    btn_pause = 1'b1; cyc(); btn_pause = 1'b0; cyc();
    check("pause_ignored", 3'd2, 2'd3, 8'd5, 1'b1);
`endif

    // Three losses; the second carries a coincident brick hit.
    lose("lost1", 2'd3, 8'd5, 1'b0, 3'd1, 2'd2, 1'b1);
    serve_to_play(2'd2, 8'd5);
    lose("lost2", 2'd2, 8'd6, 1'b1, 3'd1, 2'd1, 1'b1);
    serve_to_play(2'd1, 8'd6);
    lose("lost3", 2'd1, 8'd6, 1'b0, 3'd4, 2'd0, 1'b0);
    hit(); vsync_pulse();
    check("over_hold", 3'd4, 2'd0, 8'd6, 1'b0);
    btn_start = 1'b1; cyc(); btn_start = 1'b0;
    check("over_to_idle", 3'd0, 2'd3, 8'd0, 1'b0);
    cyc();

    // Win on the 32nd hit, coincident with a loss edge.
    press_start();
    serve_to_play(2'd3, 8'd0);
    for (int i = 0; i < 31; i++) hit();
    check("hits31", 3'd2, 2'd3, 8'd31, 1'b1);
    brick_hit = 1'b1; vsync = 1'b1; ball_y = 10'd470;
    cyc();
    brick_hit = 1'b0; vsync = 1'b0; ball_y = 10'd0;
    cyc();
    check("win", 3'd5, 2'd3, 8'd32, 1'b0);
    hit();
    check("win_hold", 3'd5, 2'd3, 8'd32, 1'b0);
    btn_start = 1'b1; cyc(); btn_start = 1'b0;
    check("win_to_idle", 3'd0, 2'd3, 8'd0, 1'b0);
    cyc();

    // Reset mid-serve at frame 30: no launch without a fresh start.
    press_start();
    for (int i = 0; i < 30; i++) vsync_pulse();
    check("serve30", 3'd1, 2'd3, 8'd0, 1'b1);
    reset_n = 1'b0;
    #1;
    check("rst_mid", 3'd0, 2'd3, 8'd0, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 70; i++) vsync_pulse();
    check("no_relaunch", 3'd0, 2'd3, 8'd0, 1'b0);
    press_start();
    serve_to_play(2'd3, 8'd0);

    cyc(); cyc();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter LIVES, default 3, lives granted per game (1..3).
REQ-002 Parameter SERVE_FRAMES, default 60, frames between serve entry and ball launch (1..255).
REQ-003 Parameter LOST_Y, default 470, ball_y threshold at or above which the ball is lost.
REQ-004 Parameter WIN_SCORE, default 32, score that ends the game as a win (1..255).
REQ-005 pxl_clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 vsync  in  1  frame sync level from the VGA timing block.
REQ-008 btn_start  in  1  synchronized start/restart button level.
REQ-009 btn_pause  in  1  synchronized pause button level.
REQ-010 ball_y  in  10  current ball vertical position.
REQ-011 brick_hit  in  1  single-cycle pulse per brick destroyed.
REQ-012 ball_start  out  1  one-cycle launch pulse to the ball mover.
REQ-013 ball_rst_n  out  1  active-low re-home of the ball mover; low re-centres ball and holds it stopped.
REQ-014 ball_vsync  out  1  gated vsync to the ball mover.
REQ-015 lives  out  2  remaining lives.
REQ-016 score  out  8  bricks destroyed this game.
REQ-017 game_state  out  3  current FSM state encoding.
REQ-018 game_over  out  1  high in OVER or WIN.

Function
REQ-019 Rising edges of vsync, btn_start and btn_pause SHALL be detected against a one-cycle registered copy; each detection asserts an internal tick for exactly one cycle.
REQ-020 States and encodings: IDLE=0, SERVE=1, PLAY=2, LOST=3, OVER=4, WIN=5, PAUSE=6; encoding 7 SHALL return to IDLE on the next cycle.
REQ-021 IDLE: lives=LIVES, score=0, ball_rst_n=0; start edge -> SERVE with the frame counter cleared.
REQ-022 SERVE: ball_rst_n=1; the 8-bit frame counter increments on each vsync tick; on the tick at which the count reaches SERVE_FRAMES, ball_start=1 for that one cycle and the FSM enters PLAY on the next edge.
REQ-023 PLAY: each brick_hit increments score, saturating at 255; once score equals WIN_SCORE the FSM enters WIN on the next cycle.
REQ-024 PLAY: on a vsync tick with ball_y >= LOST_Y the FSM enters LOST.
REQ-025 Simultaneous win and loss conditions in one cycle: WIN SHALL take priority; a brick_hit in the same cycle as a loss SHALL still be counted.
REQ-026 LOST lasts exactly one cycle: ball_rst_n=0 and lives decrements; if lives was 1, the next state is OVER with lives=0, otherwise SERVE with the frame counter cleared.
REQ-027 OVER/WIN: ball_rst_n=0; score and lives hold; start edge -> IDLE.
REQ-028 ball_vsync SHALL equal vsync combinationally in every state except PAUSE, where it is 0.
REQ-029 brick_hit SHALL be ignored outside PLAY.

Reset
REQ-030 reset_n low SHALL asynchronously force IDLE, lives=LIVES, score=0, frame counter=0, edge-detect registers=0, ball_start=0 and ball_rst_n=0, including mid-serve or mid-play.

Configuration
REQ-031 Macro GAME_PAUSE_EN defined: a pause edge in PLAY -> PAUSE; a pause edge in PAUSE -> PLAY; loss and win are not evaluated in PAUSE; a start edge in PAUSE is ignored.
REQ-032 Macro GAME_PAUSE_EN undefined: btn_pause is ignored, PAUSE is unreachable, and ball_vsync SHALL equal vsync in all states.

Verification
REQ-033 Reset, then a start edge, then 60 vsync edges -> state 1 then 2, single-cycle ball_start at the 60th tick, ball_rst_n=1.
REQ-034 In PLAY, ball_y=470 at a vsync edge -> LOST for 1 cycle, lives 3->2, ball_rst_n low for 1 cycle, back to SERVE.
REQ-035 Three losses -> OVER with lives=0 and game_over=1; a start edge -> IDLE with lives=3 and score=0.
REQ-036 31 hits, then a 32nd hit coincident with ball_y=470 at a vsync edge -> score=32, WIN, lives unchanged.
REQ-037 With GAME_PAUSE_EN: a pause edge in PLAY -> ball_vsync stays 0 across vsync pulses and ball_y=470 is ignored; a second pause edge -> PLAY.
REQ-038 Assert reset_n mid-SERVE at frame count 30 -> immediate IDLE, counter 0, and no ball_start afterwards without a new start edge.
